// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode encoding, widths and arbiter state type.
// Opcodes 10..15 are undefined and make the ALU report an error.
package alu_arbiter_pkg;

  localparam int ALU_OP_W   = 4;
  localparam int ALU_DATA_W = 32;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_OP_ADD  = 4'd0;
  localparam alu_op_t ALU_OP_SUB  = 4'd1;
  localparam alu_op_t ALU_OP_AND  = 4'd2;
  localparam alu_op_t ALU_OP_OR   = 4'd3;
  localparam alu_op_t ALU_OP_XOR  = 4'd4;
  localparam alu_op_t ALU_OP_SLL  = 4'd5;
  localparam alu_op_t ALU_OP_SRL  = 4'd6;
  localparam alu_op_t ALU_OP_SRA  = 4'd7;
  localparam alu_op_t ALU_OP_SLT  = 4'd8;
  localparam alu_op_t ALU_OP_SLTU = 4'd9;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU. Undefined opcodes produce zero data
// with err set.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [ALU_OP_W-1:0]   op,
  input  logic [ALU_DATA_W-1:0] a,
  input  logic [ALU_DATA_W-1:0] b,
  output logic [ALU_DATA_W-1:0] result,
  output logic                  err
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    result = '0;
    err    = 1'b0;
    case (op)
      ALU_OP_ADD:  result = a + b;
      ALU_OP_SUB:  result = a - b;
      ALU_OP_AND:  result = a & b;
      ALU_OP_OR:   result = a | b;
      ALU_OP_XOR:  result = a ^ b;
      ALU_OP_SLL:  result = a << b[4:0];
      ALU_OP_SRL:  result = a >> b[4:0];
      ALU_OP_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OP_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      ALU_OP_SLTU: result = {31'd0, a < b};
      default:     err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU, with a
// one-entry result register that allows back-to-back issue.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ALU_OP_W-1:0]   req0_op,
  input  logic [ALU_DATA_W-1:0] req0_a,
  input  logic [ALU_DATA_W-1:0] req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ALU_OP_W-1:0]   req1_op,
  input  logic [ALU_DATA_W-1:0] req1_a,
  input  logic [ALU_DATA_W-1:0] req1_b,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [ALU_DATA_W-1:0] rsp_data,
  output logic                  rsp_err
);

  arb_state_t            state, state_nxt;
  logic                  out_owner;
  logic                  out_err;
  logic [ALU_DATA_W-1:0] out_data;
  logic                  last_gnt;

  logic                  out_valid;
  logic                  consume;
  logic                  slot_free;
  logic                  gnt;
  logic                  accept;
  logic [ALU_OP_W-1:0]   mux_op;
  logic [ALU_DATA_W-1:0] mux_a, mux_b, alu_result;
  logic                  alu_err;

  assign out_valid = (state == ST_FULL);
  assign consume   = out_valid && (out_owner ? rsp1_ready : rsp0_ready);
  assign slot_free = !out_valid || consume;

  // On a tie the requester that did not win last time is granted.
  assign gnt    = (req0_valid && req1_valid) ? !last_gnt : req1_valid;
  assign accept = slot_free && (req0_valid || req1_valid) && rst_n;

  assign req0_ready = accept && !gnt;
  assign req1_ready = accept &&  gnt;

  assign mux_op = gnt ? req1_op : req0_op;
  assign mux_a  = gnt ? req1_a  : req0_a;
  assign mux_b  = gnt ? req1_b  : req0_b;

  alu_arbiter_alu u_alu (
    .op     (mux_op),
    .a      (mux_a),
    .b      (mux_b),
    .result (alu_result),
    .err    (alu_err)
  );

  always_comb begin
    state_nxt = state;
    if (accept)       state_nxt = ST_FULL;
    else if (consume) state_nxt = ST_EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_owner <= 1'b0;
      out_err   <= 1'b0;
      out_data  <= '0;
      last_gnt  <= 1'b1;
    end else if (accept) begin
      out_owner <= gnt;
      out_err   <= alu_err;
      out_data  <= alu_result;
      last_gnt  <= gnt;
    end
  end

  assign rsp0_valid = out_valid && !out_owner;
  assign rsp1_valid = out_valid &&  out_owner;
  assign rsp_data   = out_data;
  assign rsp_err    = out_err;

endmodule
